dbg_bridge_tx_arb: RTL and testbench
====================================

Name: dbg_bridge_tx_arb

Overview:
- Packet-atomic round-robin arbiter sharing one debug-bridge byte FIFO push port among NUM_REQ byte-stream requesters (e.g. read-response generator, write-ack generator, status/event reporter).
- Output drives the TX FIFO push/accept interface that feeds the UART transmitter.
- Once granted, a requester owns the FIFO until its byte flagged last is accepted, so frames never interleave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 8, data width per requester and at the FIFO.
- REQ_W, 1, index width; must satisfy 2**REQ_W >= NUM_REQ.
- TIMEOUT_W, 8, width of the stall watchdog counter (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_data_i  in  NUM_REQ*WIDTH  requester data; requester n occupies bits [n*WIDTH +: WIDTH].
- req_valid_i  in  NUM_REQ  requester byte valid.
- req_last_i  in  NUM_REQ  byte is the final byte of the frame.
- req_accept_o  out  NUM_REQ  byte taken from requester.
- fifo_data_o  out  WIDTH  data to FIFO.
- fifo_push_o  out  1  push strobe to FIFO.
- fifo_accept_i  in  1  FIFO has space (not full).
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high in BURST state.
- pkt_count_o  out  16  completed frames forwarded; wraps 0xFFFF -> 0.

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Registered state:
  - state_q: IDLE or BURST.
  - grant_q: owner index.
  - last_q: last owner index.
  - pkt_count_q.
- Reset values (visible after the first rising edge with rst_i=1):
  - state_q=IDLE, last_q=NUM_REQ-1 (so requester 0 wins first), pkt_count_q=0.
  - Outputs: grant_o=0, busy_o=0, fifo_push_o=0, req_accept_o=0, fifo_data_o=0, pkt_count_o=0.
- IDLE state:
  - No transfers; fifo_push_o=0 and req_accept_o=0.
  - If any req_valid_i bit is set, select the first valid requester scanning from last_q+1 upward, wrapping modulo NUM_REQ.
  - Load grant_q with that index and go to BURST.
  - Arbitration latency is 1 cycle: the earliest first-byte push is the cycle after valid is seen in IDLE.
- BURST state, owner g:
  - fifo_data_o = req_data_i[g].
  - fifo_push_o = req_valid_i[g].
  - req_accept_o[g] = fifo_accept_i. All other req_accept_o bits are 0.
  - fifo_data_o = 0 when not in BURST.
- A transfer occurs when req_valid_i[g] and fifo_accept_i are both high.
- Transfer with req_last_i[g]=1:
  - last_q <= g, pkt_count_q increments, state <= IDLE.
  - Back-to-back frames therefore cost one IDLE cycle each.
- Transfer without last: stay in BURST.
- Owner deasserts valid mid-frame: stay in BURST and hold grant; other requesters wait.
- FIFO full (fifo_accept_i=0): hold, no data loss; the requester must keep data stable while valid.
- Requesters that are non-granted but valid keep req_accept_o=0; their data is ignored.
- Single-byte frame (valid and last on the first byte): 1 cycle of BURST, then IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- rst_i asserted mid-frame: returns to the reset state on that edge; the partial frame is abandoned and pushes stop from the next cycle.
- Combinational outputs derive only from registered state and inputs; there is no combinational path from req_valid_i to grant_o.

Optional Feature:
- Macro: DBG_BRIDGE_ARB_TIMEOUT_EN.
- When defined, a TIMEOUT_W-bit stall counter runs in BURST:
  - Clears on every transfer and on entering BURST.
  - Increments on each BURST cycle with req_valid_i[g]=0.
  - Does not count while fifo_accept_i=0 and valid=1.
- When the counter reaches all-ones:
  - Forcibly return to IDLE with last_q <= g; pkt_count_q does not increment.
  - Pulse output timeout_o (1 bit, present only with the macro) for one cycle.
- When undefined, no counter and no timeout_o port; a stalled owner holds the grant indefinitely.

Test Plan:
- Reset, then req0 sends a 3-byte frame 0x11,0x22,0x33(last) with fifo_accept_i=1:
  - grant_o=01 from cycle 2.
  - Pushes on cycles 2,3,4.
  - IDLE at cycle 5; pkt_count_o=1.
- Both requesters continuously valid with 2-byte frames (req0 0xA0,0xA1; req1 0xB0,0xB1):
  - FIFO sees A0 A1 B0 B1 A0 A1, never interleaved.
  - grant_o toggles 01 -> 10 -> 01.
- fifo_accept_i=0 for 4 cycles mid-frame after byte 0x22:
  - fifo_push_o stays high and req_accept_o[0]=0 during the stall.
  - 0x33 is pushed exactly once after release; no duplicate or lost byte.
- req1 valid while req0 mid-frame with valid gaps: req1 gets no accept until req0's last byte is accepted, then grant_o=10 one IDLE cycle later.
- rst_i pulsed one cycle during byte 2 of a 4-byte frame:
  - Next cycle grant_o=0, fifo_push_o=0, pkt_count_o=0.
  - Requester 0 wins the next arbitration.
- With DBG_BRIDGE_ARB_TIMEOUT_EN and TIMEOUT_W=4, req0 sends one byte without last then drops valid:
  - timeout_o pulses after 15 idle BURST cycles; state returns to IDLE.
  - pkt_count_o unchanged; waiting req1 is granted next.

Source files
------------

// File: rtl/dbg_bridge_tx_arb.sv
// Packet-atomic round-robin arbiter for the debug-bridge TX FIFO push port.
// A granted requester keeps the FIFO until its last-flagged byte is accepted,
// so frames from different requesters never interleave on the UART.
// Optional stall watchdog: define DBG_BRIDGE_ARB_TIMEOUT_EN to add a
// TIMEOUT_W-bit counter and the timeout_o pulse output.
module dbg_bridge_tx_arb #(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH     = 8,
    parameter int REQ_W     = 1,
    parameter int TIMEOUT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_accept_o,
    output logic [WIDTH-1:0]         fifo_data_o,
    output logic                     fifo_push_o,
    input  logic                     fifo_accept_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
`ifdef DBG_BRIDGE_ARB_TIMEOUT_EN
    output logic                     timeout_o,
`endif
    output logic [15:0]              pkt_count_o
);

    typedef enum logic {IDLE, BURST} state_e;

    state_e             state_q, state_d;
    logic [REQ_W-1:0]   grant_q, grant_d;
    logic [REQ_W-1:0]   last_q, last_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic               own_valid;
    logic               own_last;
    logic [WIDTH-1:0]   own_data;
    logic               any_valid;
    logic [REQ_W-1:0]   pick;
    logic [REQ_W-1:0]   cand;
    logic               xfer;
    logic               stall_expire;

    // Mux the current owner's byte stream out of the flattened requester buses.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant_q == REQ_W'(n)) begin
                own_valid = req_valid_i[n];
                own_last  = req_last_i[n];
                own_data  = req_data_i[n*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pick: first valid requester scanning upward from last_q+1.
    always_comb begin
        any_valid = 1'b0;
        pick      = last_q;
        cand      = last_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == REQ_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!any_valid && req_valid_i[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    assign xfer = (state_q == BURST) && own_valid && fifo_accept_i;

`ifdef DBG_BRIDGE_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] stall_q, stall_d;

    // Watchdog only counts cycles where the owner has nothing to offer;
    // a full FIFO is back-pressure, not a stall.
    always_comb begin
        stall_d = stall_q;
        if (state_q != BURST || xfer) begin
            stall_d = '0;
        end else if (!own_valid) begin
            stall_d = stall_expire ? '0 : stall_q + 1'b1;
        end
    end

    assign stall_expire = (state_q == BURST) && !own_valid && (stall_q == '1);
    assign timeout_o    = stall_expire;

    // Watchdog counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end
`else
    assign stall_expire = 1'b0;
`endif

    // Next-state logic: grant on any request in IDLE, release on last byte.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer && own_last) begin
                    last_d      = grant_q;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end else if (stall_expire) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset biases the first grant to requester 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= REQ_W'(NUM_REQ - 1);
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // FIFO-side outputs come only from the owner while in BURST.
    always_comb begin
        grant_o      = '0;
        req_accept_o = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            grant_o[n]      = (state_q == BURST) && (grant_q == REQ_W'(n));
            req_accept_o[n] = grant_o[n] && fifo_accept_i;
        end
        busy_o      = (state_q == BURST);
        fifo_push_o = (state_q == BURST) && own_valid;
        fifo_data_o = (state_q == BURST) ? own_data : '0;
        pkt_count_o = pkt_count_q;
    end

endmodule

// File: tb/tb_dbg_bridge_tx_arb.sv
// Testbench for dbg_bridge_tx_arb: queue-driven requester models feed the
// arbiter, a scoreboard holds the hand-ordered expected FIFO byte stream,
// and an independent monitor checks every accepted push against it.
module tb_dbg_bridge_tx_arb;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] g;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] reqData;
   logic [1:0]  reqValid;
   logic [1:0]  reqLast;
   logic [1:0]  reqAccept;
   logic [7:0]  fifoData;
   logic        fifoPush;
   logic        fifoAccept;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] pktCount;
`ifdef DBG_BRIDGE_ARB_TIMEOUT_EN
   logic        timeout;
`endif

   beat_t src0[$];
   beat_t src1[$];
   logic  hold0 = 1'b0;
   exp_t  expQ[$];

   int checks = 0;
   int errors = 0;

   dbg_bridge_tx_arb #(
      .NUM_REQ(2), .WIDTH(8), .REQ_W(1), .TIMEOUT_W(4)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .req_data_i(reqData),
      .req_valid_i(reqValid),
      .req_last_i(reqLast),
      .req_accept_o(reqAccept),
      .fifo_data_o(fifoData),
      .fifo_push_o(fifoPush),
      .fifo_accept_i(fifoAccept),
      .grant_o(grant),
      .busy_o(busy),
`ifdef DBG_BRIDGE_ARB_TIMEOUT_EN
      .timeout_o(timeout),
`endif
      .pkt_count_o(pktCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Compare one observed value with its hand-computed expectation
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue one byte on a requester's source model
   task automatic applyStimulus(input int req, input logic [7:0] d, input logic l);
      beat_t b;
      b.d = d;
      b.l = l;
      if (req == 0) src0.push_back(b);
      else          src1.push_back(b);
   endtask

   // Record one byte the FIFO must receive, with the owner expected to send it
   task automatic expectPush(input logic [7:0] d, input logic [1:0] g);
      exp_t e;
      e.d = d;
      e.g = g;
      expQ.push_back(e);
   endtask

   task automatic nextNeg(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic startCycle();
      @(posedge clk);
      #1;
   endtask

   // One-cycle synchronous reset; returns at the start of the first post-reset cycle
   task automatic doReset();
      startCycle();
      rst = 1'b1;
      startCycle();
      rst = 1'b0;
   endtask

   // Requester models: present the queue head, retire it when the arbiter accepts
   initial begin : driver
      logic [1:0] took;
      reqValid = '0;
      reqLast  = '0;
      reqData  = '0;
      forever begin
         @(negedge clk);
         took = reqValid & reqAccept;
         @(posedge clk);
         #2;
         if (took[0] && src0.size() > 0) void'(src0.pop_front());
         if (took[1] && src1.size() > 0) void'(src1.pop_front());
         reqValid[0]   = (src0.size() > 0) && !hold0;
         reqData[7:0]  = (src0.size() > 0) ? src0[0].d : 8'h00;
         reqLast[0]    = (src0.size() > 0) ? src0[0].l : 1'b0;
         reqValid[1]   = (src1.size() > 0);
         reqData[15:8] = (src1.size() > 0) ? src1[0].d : 8'h00;
         reqLast[1]    = (src1.size() > 0) ? src1[0].l : 1'b0;
      end
   end

   // Scoreboard monitor: every accepted push must match the next expected byte
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (fifoPush && fifoAccept) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_push: got data %0h grant %0b with nothing expected at %0t",
                        fifoData, grant, $time);
            end else begin
               e = expQ.pop_front();
               if (fifoData !== e.d || grant !== e.g) begin
                  errors++;
                  $display("[TB] FAIL push: got data %0h grant %0b expected data %0h grant %0b at %0t",
                           fifoData, grant, e.d, e.g, $time);
               end
            end
         end
      end
   end

   // Directed scenarios with cycle-accurate expectations
   initial begin : mainSeq
      rst        = 1'b1;
      fifoAccept = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_grant", grant, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_push", fifoPush, 0);
      checkOutput("reset_accept", reqAccept, 0);
      checkOutput("reset_data", fifoData, 0);
      checkOutput("reset_pkt", pktCount, 0);
      startCycle();
      rst = 1'b0;

      $display("[TB] three-byte frame from requester 0");
      applyStimulus(0, 8'h11, 0); applyStimulus(0, 8'h22, 0); applyStimulus(0, 8'h33, 1);
      expectPush(8'h11, 2'b01); expectPush(8'h22, 2'b01); expectPush(8'h33, 2'b01);
      nextNeg(1); checkOutput("t1_c1_grant", grant, 0);
      nextNeg(1); checkOutput("t1_c2_grant", grant, 2'b01);
      checkOutput("t1_c2_busy", busy, 1);
      nextNeg(3); checkOutput("t1_c5_grant", grant, 0);
      checkOutput("t1_c5_busy", busy, 0);
      checkOutput("t1_c5_pkt", pktCount, 1);

      $display("[TB] two requesters, back-to-back two-byte frames");
      doReset();
      applyStimulus(0, 8'hA0, 0); applyStimulus(0, 8'hA1, 1);
      applyStimulus(0, 8'hA0, 0); applyStimulus(0, 8'hA1, 1);
      applyStimulus(1, 8'hB0, 0); applyStimulus(1, 8'hB1, 1);
      expectPush(8'hA0, 2'b01); expectPush(8'hA1, 2'b01);
      expectPush(8'hB0, 2'b10); expectPush(8'hB1, 2'b10);
      expectPush(8'hA0, 2'b01); expectPush(8'hA1, 2'b01);
      nextNeg(2); checkOutput("t2_c2_grant", grant, 2'b01);
      nextNeg(3); checkOutput("t2_c5_grant", grant, 2'b10);
      nextNeg(3); checkOutput("t2_c8_grant", grant, 2'b01);
      nextNeg(2); checkOutput("t2_c10_grant", grant, 0);
      checkOutput("t2_c10_pkt", pktCount, 3);

      $display("[TB] FIFO full for four cycles mid-frame");
      doReset();
      applyStimulus(0, 8'h11, 0); applyStimulus(0, 8'h22, 0); applyStimulus(0, 8'h33, 1);
      expectPush(8'h11, 2'b01); expectPush(8'h22, 2'b01); expectPush(8'h33, 2'b01);
      nextNeg(3);
      startCycle();
      fifoAccept = 1'b0;
      nextNeg(1); checkOutput("t3_stall_push", fifoPush, 1);
      checkOutput("t3_stall_accept", reqAccept, 0);
      checkOutput("t3_stall_data", fifoData, 8'h33);
      nextNeg(3); checkOutput("t3_stall_push_late", fifoPush, 1);
      checkOutput("t3_stall_accept_late", reqAccept, 0);
      startCycle();
      fifoAccept = 1'b1;
      nextNeg(2); checkOutput("t3_done_grant", grant, 0);
      checkOutput("t3_done_pkt", pktCount, 1);

      $display("[TB] owner with valid gaps keeps the grant");
      doReset();
      applyStimulus(0, 8'h01, 0); applyStimulus(0, 8'h02, 0); applyStimulus(0, 8'h03, 1);
      applyStimulus(1, 8'h44, 1);
      expectPush(8'h01, 2'b01); expectPush(8'h02, 2'b01); expectPush(8'h03, 2'b01);
      expectPush(8'h44, 2'b10);
      nextNeg(2);
      startCycle();
      hold0 = 1'b1;
      nextNeg(1); checkOutput("t4_gap_grant", grant, 2'b01);
      checkOutput("t4_gap_accept", reqAccept, 2'b01);
      checkOutput("t4_gap_push", fifoPush, 0);
      nextNeg(1); checkOutput("t4_gap2_grant", grant, 2'b01);
      startCycle();
      hold0 = 1'b0;
      nextNeg(3); checkOutput("t4_idle_grant", grant, 0);
      nextNeg(1); checkOutput("t4_req1_grant", grant, 2'b10);
      nextNeg(1); checkOutput("t4_done_pkt", pktCount, 2);

      $display("[TB] reset during a four-byte frame");
      startCycle();
      applyStimulus(1, 8'h51, 0); applyStimulus(1, 8'h52, 0);
      applyStimulus(1, 8'h53, 0); applyStimulus(1, 8'h54, 1);
      expectPush(8'h51, 2'b10); expectPush(8'h52, 2'b10);
      expectPush(8'h66, 2'b01);
      expectPush(8'h53, 2'b10); expectPush(8'h54, 2'b10);
      nextNeg(2); checkOutput("t5_c2_grant", grant, 2'b10);
      startCycle();
      rst = 1'b1;
      applyStimulus(0, 8'h66, 1);
      startCycle();
      rst = 1'b0;
      nextNeg(1); checkOutput("t5_rst_grant", grant, 0);
      checkOutput("t5_rst_push", fifoPush, 0);
      checkOutput("t5_rst_pkt", pktCount, 0);
      nextNeg(1); checkOutput("t5_req0_wins", grant, 2'b01);
      nextNeg(2); checkOutput("t5_req1_resume", grant, 2'b10);
      nextNeg(2); checkOutput("t5_done_pkt", pktCount, 2);

`ifdef DBG_BRIDGE_ARB_TIMEOUT_EN
      $display("[TB] stalled owner released by watchdog");
      doReset();
      applyStimulus(0, 8'h77, 0);
      applyStimulus(1, 8'h88, 1);
      expectPush(8'h77, 2'b01); expectPush(8'h88, 2'b10);
      nextNeg(17); checkOutput("t6_before_timeout", timeout, 0);
      checkOutput("t6_hold_grant", grant, 2'b01);
      nextNeg(1); checkOutput("t6_timeout_pulse", timeout, 1);
      nextNeg(1); checkOutput("t6_after_timeout", timeout, 0);
      checkOutput("t6_idle_grant", grant, 0);
      checkOutput("t6_pkt_unchanged", pktCount, 0);
      nextNeg(1); checkOutput("t6_req1_grant", grant, 2'b10);
      nextNeg(1); checkOutput("t6_done_pkt", pktCount, 1);
`endif

      nextNeg(2);
      checkOutput("scoreboard_drained", 16'(expQ.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
